// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory instance between the CPU MEM stage and a DMA/debug loader.
// Round-robin arbitration by default; define DMEM_ARB_CPU_PRIO_EN for fixed CPU priority.
`timescale 1ns/1ps
module dmem_port_arbiter #(
  parameter int MEM_LAT = 3,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              grant_dma
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              owner_dma;
  logic              last_grant_dma;
  logic              lat_we;
  logic [DATA_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              pick_any;
  logic              pick_dma;

  always_comb begin
    pick_any = cpu_req | dma_req;
`ifdef DMEM_ARB_CPU_PRIO_EN
    pick_dma = dma_req & ~cpu_req;
`else
    // On a tie the port that was not served last wins.
    pick_dma = dma_req & (~cpu_req | ~last_grant_dma);
`endif
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_write      = (state == BUSY) && (cnt == 4'd0) && lat_we;
    mem_address    = (state == BUSY) ? lat_addr  : '0;
    mem_write_data = (state == BUSY) ? lat_wdata : '0;
    cpu_ack        = (state == DONE) && !owner_dma;
    dma_ack        = (state == DONE) && owner_dma;
    cpu_stall      = cpu_req & ~cpu_ack;
    grant_dma      = owner_dma;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      owner_dma      <= 1'b0;
      last_grant_dma <= 1'b1;
      lat_we         <= 1'b0;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      cpu_rdata      <= '0;
      dma_rdata      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_any) begin
            owner_dma <= pick_dma;
            lat_we    <= pick_dma ? dma_we    : cpu_we;
            lat_addr  <= pick_dma ? dma_addr  : cpu_addr;
            lat_wdata <= pick_dma ? dma_wdata : cpu_wdata;
            cnt       <= CNT_INIT;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!lat_we) begin
            // Stores leave the owner's read data untouched.
            if (owner_dma) dma_rdata <= mem_read_data;
            else           cpu_rdata <= mem_read_data;
          end
        end
        DONE: last_grant_dma <= owner_dma;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboarded bench for dmem_port_arbiter: MEM_LAT=3 main instance plus a MEM_LAT=1 instance.
// Expectations adapt to DMEM_ARB_CPU_PRIO_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [DW-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_ack;
  logic [DW-1:0] dma_addr, dma_wdata, dma_rdata;
  logic          mem_write, grant_dma;
  logic [DW-1:0] mem_address, mem_write_data, mem_read_data;

  logic          l1_cpu_req, l1_cpu_we, l1_cpu_ack, l1_cpu_stall;
  logic [DW-1:0] l1_cpu_addr, l1_cpu_wdata, l1_cpu_rdata;
  logic          l1_dma_req, l1_dma_we, l1_dma_ack;
  logic [DW-1:0] l1_dma_addr, l1_dma_wdata, l1_dma_rdata;
  logic          l1_mem_write, l1_grant_dma;
  logic [DW-1:0] l1_mem_address, l1_mem_write_data, l1_mem_read_data;

  dmem_port_arbiter #(.MEM_LAT(3), .DATA_W(DW)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_write(mem_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .grant_dma(grant_dma)
  );

  dmem_port_arbiter #(.MEM_LAT(1), .DATA_W(DW)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .cpu_req(l1_cpu_req), .cpu_we(l1_cpu_we), .cpu_addr(l1_cpu_addr), .cpu_wdata(l1_cpu_wdata),
    .cpu_rdata(l1_cpu_rdata), .cpu_ack(l1_cpu_ack), .cpu_stall(l1_cpu_stall),
    .dma_req(l1_dma_req), .dma_we(l1_dma_we), .dma_addr(l1_dma_addr), .dma_wdata(l1_dma_wdata),
    .dma_rdata(l1_dma_rdata), .dma_ack(l1_dma_ack),
    .mem_write(l1_mem_write), .mem_address(l1_mem_address), .mem_write_data(l1_mem_write_data),
    .mem_read_data(l1_mem_read_data), .grant_dma(l1_grant_dma)
  );

  // Shared async-read memory; only the main instance writes, the bench preloads during reset.
  logic [DW-1:0] mem [0:63];
  logic          pl_en = 1'b0;
  logic [5:0]    pl_idx;
  logic [DW-1:0] pl_data;
  always @(posedge clk) begin
    if (pl_en)          mem[pl_idx] <= pl_data;
    else if (mem_write) mem[mem_address[7:2]] <= mem_write_data;
  end
  assign mem_read_data    = mem[mem_address[7:2]];
  assign l1_mem_read_data = mem[l1_mem_address[7:2]];

  int errors = 0;
  int checks = 0;

  task automatic chk_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          is_dma;
    logic          is_load;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t sb_e;

  task automatic push(input logic is_dma, input logic is_load, input logic [DW-1:0] rdata);
    exp_t e;
    e.is_dma = is_dma; e.is_load = is_load; e.rdata = rdata;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset && (cpu_ack || dma_ack)) begin
      chk_val("ack_exclusive", 32'(cpu_ack & dma_ack), 32'd0);
      if (sb.size() == 0) begin
        chk_val("sb_unexpected_ack", 32'd1, 32'd0);
      end else begin
        sb_e = sb.pop_front();
        chk_val("sb_port", 32'(dma_ack), 32'(sb_e.is_dma));
        if (sb_e.is_load) chk_val("sb_rdata", sb_e.is_dma ? dma_rdata : cpu_rdata, sb_e.rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    l1_cpu_req = 0; l1_cpu_we = 0; l1_cpu_addr = '0; l1_cpu_wdata = '0;
    l1_dma_req = 0; l1_dma_we = 0; l1_dma_addr = '0; l1_dma_wdata = '0;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [DW-1:0] data);
    pl_en = 1'b1; pl_idx = idx; pl_data = data;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic release_reset();
    tick();
    reset = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk_val({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    chk_val({tag, "_dma_ack"}, 32'(dma_ack), 32'd0);
    chk_val({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    chk_val({tag, "_dma_rdata"}, dma_rdata, 32'd0);
    chk_val({tag, "_mem_address"}, mem_address, 32'd0);
    chk_val({tag, "_mem_write_data"}, mem_write_data, 32'd0);
    chk_val({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    chk_val({tag, "_grant_dma"}, 32'(grant_dma), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    #2 reset = 1'b0;

    // Reset state, then a single CPU load
    @(negedge clk);
    chk_reset_outputs("rst");
    chk_val("rst_stall", 32'(cpu_stall), 32'd0);
    preload(6'd16, 32'h1234_5678);
    release_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    push(1'b0, 1'b1, 32'h1234_5678);
    for (int k = 0; k <= 5; k++) begin
      if (k == 5) cpu_req = 0;
      @(negedge clk);
      if (k <= 4) begin
        chk_val("t1_stall", 32'(cpu_stall), 32'(k < 4));
        chk_val("t1_cpu_ack", 32'(cpu_ack), 32'(k == 4));
      end
      chk_val("t1_mem_write", 32'(mem_write), 32'd0);
      if (k == 4) chk_val("t1_cpu_rdata", cpu_rdata, 32'h1234_5678);
      tick();
    end

    // Simultaneous CPU store and DMA load of the same word
    reset = 1'b0;
    release_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
    dma_req = 1; dma_we = 0; dma_addr = 32'h10;
    push(1'b0, 1'b0, 32'h0);
    push(1'b1, 1'b1, 32'hDEAD_BEEF);
    for (int k = 0; k <= 10; k++) begin
      if (k == 5)  cpu_req = 0;
      if (k == 10) dma_req = 0;
      @(negedge clk);
      chk_val("t2_mem_write", 32'(mem_write), 32'(k == 3));
      chk_val("t2_grant_dma", 32'(grant_dma), 32'(k >= 6));
      chk_val("t2_cpu_ack", 32'(cpu_ack), 32'(k == 4));
      chk_val("t2_dma_ack", 32'(dma_ack), 32'(k == 9));
      if (k == 3) chk_val("t2_mem_address", mem_address, 32'h10);
      if (k == 4) chk_val("t2_store_rdata", cpu_rdata, 32'h0);
      if (k == 9) chk_val("t2_mem_word", mem[4], 32'hDEAD_BEEF);
      tick();
    end

    // Both ports re-requesting continuously
    reset = 1'b0;
    release_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    dma_req = 1; dma_we = 0; dma_addr = 32'h10;
`ifdef DMEM_ARB_CPU_PRIO_EN
    for (int i = 0; i < 4; i++) push(1'b0, 1'b1, 32'h1234_5678);
    push(1'b1, 1'b1, 32'hDEAD_BEEF);
    for (int k = 0; k <= 25; k++) begin
      if (k == 20) cpu_req = 0;
      if (k == 25) dma_req = 0;
      @(negedge clk);
      chk_val("t3_cpu_ack", 32'(cpu_ack), 32'(k inside {4, 9, 14, 19}));
      chk_val("t3_dma_ack", 32'(dma_ack), 32'(k == 24));
      if (k % 5 == 2) chk_val("t3_grant_dma", 32'(grant_dma), 32'(k >= 20));
      tick();
    end
`else
    push(1'b0, 1'b1, 32'h1234_5678);
    push(1'b1, 1'b1, 32'hDEAD_BEEF);
    push(1'b0, 1'b1, 32'h1234_5678);
    push(1'b1, 1'b1, 32'hDEAD_BEEF);
    for (int k = 0; k <= 20; k++) begin
      if (k == 20) begin cpu_req = 0; dma_req = 0; end
      @(negedge clk);
      chk_val("t3_cpu_ack", 32'(cpu_ack), 32'(k inside {4, 14}));
      chk_val("t3_dma_ack", 32'(dma_ack), 32'(k inside {9, 19}));
      if (k % 5 == 2) chk_val("t3_grant_dma", 32'((k / 5) % 2), 32'(grant_dma));
      tick();
    end
`endif

    // Reset during a DMA store, then a tie after release
    reset = 1'b0;
    preload(6'd8, 32'h0BAD_F00D);
    release_reset();
    dma_req = 1; dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'hCAFE_F00D;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_val("t4_mem_write_pre", 32'(mem_write), 32'd0);
      tick();
    end
    reset = 1'b0;
    dma_req = 0;
    @(negedge clk);
    chk_reset_outputs("t4_abort");
    tick();
    tick();
    chk_val("t4_mem_word", mem[8], 32'h0BAD_F00D);
    release_reset();
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40;
    dma_req = 1; dma_we = 0; dma_addr = 32'h20;
    push(1'b0, 1'b1, 32'h1234_5678);
    push(1'b1, 1'b1, 32'h0BAD_F00D);
    for (int k = 0; k <= 10; k++) begin
      if (k == 5)  cpu_req = 0;
      if (k == 10) dma_req = 0;
      @(negedge clk);
      if (k == 0) chk_val("t4_stall_after_release", 32'(cpu_stall), 32'd1);
      if (k == 2) chk_val("t4_grant_dma", 32'(grant_dma), 32'd0);
      chk_val("t4_cpu_ack", 32'(cpu_ack), 32'(k == 4));
      chk_val("t4_dma_ack", 32'(dma_ack), 32'(k == 9));
      tick();
    end

    // MEM_LAT=1 instance: CPU load
    l1_cpu_req = 1; l1_cpu_we = 0; l1_cpu_addr = 32'h40;
    for (int k = 0; k <= 3; k++) begin
      if (k == 3) l1_cpu_req = 0;
      @(negedge clk);
      if (k == 1) chk_val("t5_mem_address", l1_mem_address, 32'h40);
      chk_val("t5_cpu_ack", 32'(l1_cpu_ack), 32'(k == 2));
      if (k <= 2) chk_val("t5_stall", 32'(l1_cpu_stall), 32'(k < 2));
      chk_val("t5_mem_write", 32'(l1_mem_write), 32'd0);
      if (k == 2) chk_val("t5_cpu_rdata", l1_cpu_rdata, 32'h1234_5678);
      tick();
    end

    chk_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
